ct_spsram_pipe: RTL and testbench
=================================

CT_SPSRAM_PIPE -- requirements
Module: ct_spsram_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning address bits; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 59, meaning word width in bits.
REQ-003 SHALL have parameter OUT_REG, default 1, meaning 0 = no output register, 1 = registered read output.
REQ-004 SHALL have parameter INIT_EN, default 1, meaning 1 = zero-fill the array after reset.
REQ-005 SHALL have port CLK  input  1  meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-007 SHALL have port REQ_VLD  input  1  meaning request valid.
REQ-008 SHALL have port REQ_RDY  output  1  meaning request accepted when REQ_VLD and REQ_RDY are both high.
REQ-009 SHALL have port REQ_WR  input  1  meaning 1 = write, 0 = read.
REQ-010 SHALL have port REQ_ADDR  input  ADDR_WIDTH  meaning word address.
REQ-011 SHALL have port REQ_WDATA  input  DATA_WIDTH  meaning write data.
REQ-012 SHALL have port REQ_WMASK  input  DATA_WIDTH  meaning active-high per-bit write enable.
REQ-013 SHALL have port RSP_VLD  output  1  meaning read data valid, a single-cycle pulse.
REQ-014 SHALL have port RSP_RDATA  output  DATA_WIDTH  meaning read data.
REQ-015 SHALL have port INIT_DONE  output  1  meaning the array is initialised and requests are accepted.

Function
REQ-016 SHALL implement states INIT and RUN.
REQ-017 INIT SHALL step a counter from 0 to 2**ADDR_WIDTH-1, writing all-zero with full mask at one address per cycle.
REQ-018 The cycle after the write to address 2**ADDR_WIDTH-1, the FSM SHALL enter RUN.
REQ-019 With INIT_EN=0, the FSM SHALL enter RUN on the first cycle after RST deasserts.
REQ-020 REQ_RDY and INIT_DONE SHALL both equal (state==RUN); there is no other backpressure.
REQ-021 An accepted write SHALL update only the bits with REQ_WMASK=1; unmasked bits SHALL keep their old value.
REQ-022 Memory-array write enables SHALL be active-low per bit, driven as the inversion of REQ_WMASK, with an active-low global write enable.
REQ-023 Chip enable SHALL be active-low, asserted only on an accepted request or an INIT write.
REQ-024 A read accepted in cycle t SHALL raise RSP_VLD in cycle t+1 (OUT_REG=0) or t+2 (OUT_REG=1), for exactly one cycle per read.
REQ-025 Back-to-back reads SHALL sustain one response per cycle, with responses in request order.
REQ-026 A read of address X accepted the cycle after a write to X SHALL return the newly written data.
REQ-027 Writes SHALL produce no response.
REQ-028 RSP_RDATA SHALL hold its last value while RSP_VLD is low.
REQ-029 An all-zero REQ_WMASK write SHALL be accepted and SHALL leave memory unchanged.

Reset
REQ-030 While RST is high: state=INIT (or RUN next cycle if INIT_EN=0), counter=0, REQ_RDY=0, INIT_DONE=0, RSP_VLD=0, RSP_RDATA=0, pipeline valids cleared.
REQ-031 RST asserted mid-INIT or mid-RUN SHALL abort in-flight reads with no RSP_VLD and SHALL restart INIT from address 0.
REQ-032 Memory contents SHALL not be reset except by the INIT sweep.

Structure
REQ-033 Package ct_spsram_pkg SHALL hold the state enum (INIT, RUN) and the OUT_REG encoding constants.
REQ-034 The array SHALL be a single sub-module ct_f_spsram_param (ports A, CEN, CLK, D, GWEN, Q, WEN), parametrised by ADDR_WIDTH and DATA_WIDTH, with 1-cycle read latency.
REQ-035 The wrapper SHALL contain the FSM, init counter, request mux, response valid pipeline and optional output register.

Verification
REQ-036 Reset with ADDR_WIDTH=4, INIT_EN=1 -> INIT_DONE rises exactly 17 cycles after RST falls; reading all 16 addresses returns 0.
REQ-037 Write 0x5A5 to address 3 with full mask, then read address 3 the next cycle, OUT_REG=1 -> RSP_VLD 2 cycles after the read, RSP_RDATA=0x5A5.
REQ-038 Write all-ones to address 7, then write 0 with mask 0x00F, then read -> data = all-ones with bits [3:0]=0.
REQ-039 Reads to addresses 1,2,3 on consecutive cycles, OUT_REG=0 -> three consecutive RSP_VLD pulses with data in order 1,2,3.
REQ-040 RST pulse while a read is in flight -> no RSP_VLD, REQ_RDY=0, INIT restarts at address 0.
REQ-041 REQ_VLD high during INIT -> REQ_RDY=0, memory unchanged, no response.

Source files
------------

// File: rtl/ct_spsram_pkg.sv
// ----------------------------------------------------------------------------
// ct_spsram_pkg
// Shared types and constants for the pipelined single-port SRAM wrapper.
//   state_t       : wrapper FSM states (INIT sweep, RUN for normal traffic)
//   OUT_REG_NONE  : OUT_REG value selecting an unregistered read path
//   OUT_REG_ON    : OUT_REG value selecting a registered read path
// ----------------------------------------------------------------------------
package ct_spsram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int OUT_REG_NONE = 0;
  localparam int OUT_REG_ON   = 1;

endpackage

// File: rtl/ct_f_spsram_param.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_param
// Behavioural single-port SRAM macro with one cycle of read latency.
// Ports:
//   A    : word address
//   CEN  : chip enable, active-low
//   CLK  : clock, rising edge
//   D    : write data
//   GWEN : global write enable, active-low (high with CEN low = read)
//   Q    : read data, updated only by a read, holds otherwise
//   WEN  : per-bit write enable, active-low
// ----------------------------------------------------------------------------
module ct_f_spsram_param
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 59
) (
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  CLK,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic [DATA_WIDTH-1:0] WEN
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // A selected write merges new data only into bits whose WEN is low, so a
  // fully-high WEN leaves the word untouched. A read loads Q, which then
  // holds until the next read. The array itself has no reset.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/ct_spsram_pipe.sv
// ----------------------------------------------------------------------------
// ct_spsram_pipe
// Single-port SRAM wrapper: zero-fill sweep after reset, valid/ready request
// port, and a read response pipeline with an optional output register.
// Ports:
//   CLK, RST         : clock and synchronous active-high reset
//   REQ_VLD/REQ_RDY  : request handshake; REQ_RDY is high only in RUN
//   REQ_WR           : 1 = write, 0 = read
//   REQ_ADDR         : word address
//   REQ_WDATA        : write data
//   REQ_WMASK        : per-bit write enable, active-high
//   RSP_VLD          : one-cycle pulse per read response
//   RSP_RDATA        : read data, holds while RSP_VLD is low
//   INIT_DONE        : sweep complete, requests accepted
// ----------------------------------------------------------------------------
module ct_spsram_pipe
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 59,
  parameter int OUT_REG    = 1,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VLD,
  output logic                  REQ_RDY,
  input  logic                  REQ_WR,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [DATA_WIDTH-1:0] REQ_WMASK,
  output logic                  RSP_VLD,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  INIT_DONE
);

  localparam bit INIT_ON = (INIT_EN != 0);
  localparam bit REG_ON  = (OUT_REG == OUT_REG_ON);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH:0]   init_cnt;
  logic                  init_wr;
  logic                  run_ok;
  logic                  req_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_cen;
  logic                  mem_gwen;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0] mem_wen;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  rd_vld1;
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;

  // State register; reset always returns to the INIT sweep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // The sweep counter carries one extra bit: once it reaches the depth the
  // final zero write has already been issued, and the FSM moves to RUN on
  // the following edge. Without the sweep, RUN follows reset immediately.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (!INIT_ON || init_cnt[ADDR_WIDTH]) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs. Both are masked by RST so nothing is accepted or written
  // in a cycle that is being reset.
  always_comb begin
    run_ok  = (state == RUN) && !RST;
    init_wr = (state == INIT) && INIT_ON && !init_cnt[ADDR_WIDTH] && !RST;
  end

  // Sweep address counter, advancing once per zero write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      init_cnt <= '0;
    end else if (init_wr) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  assign REQ_RDY   = run_ok;
  assign INIT_DONE = run_ok;
  assign req_acc   = REQ_VLD & run_ok;
  assign rd_acc    = req_acc & ~REQ_WR;

  // Memory port mux. Sweep writes and accepted requests never overlap since
  // requests are only accepted in RUN. Macro enables are active-low, so the
  // active-high request mask is inverted onto WEN.
  always_comb begin
    mem_cen  = ~(init_wr | req_acc);
    mem_gwen = ~(init_wr | (req_acc & REQ_WR));
    mem_a    = REQ_ADDR;
    mem_d    = REQ_WDATA;
    mem_wen  = ~REQ_WMASK;
    if (init_wr) begin
      mem_a   = init_cnt[ADDR_WIDTH-1:0];
      mem_d   = '0;
      mem_wen = '0;
    end
  end

  ct_f_spsram_param #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .A    (mem_a),
    .CEN  (mem_cen),
    .CLK  (CLK),
    .D    (mem_d),
    .GWEN (mem_gwen),
    .Q    (mem_q),
    .WEN  (mem_wen)
  );

  // Response pipeline. rd_vld1 marks the cycle the macro Q holds fresh read
  // data; the second stage and the data register form the optional output
  // register. The data register also supplies the held value on the
  // unregistered path, so RSP_RDATA never shows stale macro output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld1    <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rd_vld1   <= rd_acc;
      rsp_vld_q <= rd_vld1;
      if (rd_vld1) begin
        rsp_data_q <= mem_q;
      end
    end
  end

  assign RSP_VLD   = ~RST & (REG_ON ? rsp_vld_q : rd_vld1);
  assign RSP_RDATA = RST ? '0 :
                     (REG_ON ? rsp_data_q : (rd_vld1 ? mem_q : rsp_data_q));

endmodule

// File: tb/tb_ct_spsram_pipe.sv
// ----------------------------------------------------------------------------
// tb_ct_spsram_pipe
// Drives two wrappers (OUT_REG=0 and OUT_REG=1, depth 16) with identical
// requests. A reference memory produces expected read data and arrival
// cycles into one scoreboard queue per instance; the response monitor pops
// and compares them, and checks the hold and reset behaviour of the outputs.
// ----------------------------------------------------------------------------
module tb_ct_spsram_pipe;

  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_entry_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          req_vld   = 1'b0;
  logic          req_wr    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic [1:0]    req_rdy;
  logic [1:0]    init_done;
  logic [1:0]    rsp_vld;
  logic [DW-1:0] rsp_rdata [2];

  sb_entry_t     sbq0 [$];
  sb_entry_t     sbq1 [$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_data [2];
  bit            exp_run   = 1'b0;
  int            compared  = 0;
  int            mismatched = 0;
  int            cyc       = 0;

  always #5 clk = ~clk;

  ct_spsram_pipe #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OUT_REG    (0),
    .INIT_EN    (1)
  ) u_dut0 (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VLD   (req_vld),
    .REQ_RDY   (req_rdy[0]),
    .REQ_WR    (req_wr),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .REQ_WMASK (req_wmask),
    .RSP_VLD   (rsp_vld[0]),
    .RSP_RDATA (rsp_rdata[0]),
    .INIT_DONE (init_done[0])
  );

  ct_spsram_pipe #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OUT_REG    (1),
    .INIT_EN    (1)
  ) u_dut1 (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VLD   (req_vld),
    .REQ_RDY   (req_rdy[1]),
    .REQ_WR    (req_wr),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .REQ_WMASK (req_wmask),
    .RSP_VLD   (rsp_vld[1]),
    .RSP_RDATA (rsp_rdata[1]),
    .INIT_DONE (init_done[1])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one request cycle at the falling edge. When the request is
  // expected to be accepted, the reference memory is updated for writes,
  // and for reads the expected data is queued with its arrival cycle: one
  // edge after acceptance for OUT_REG=0, two for OUT_REG=1.
  task automatic applyStimulus(input logic vld, input logic wr,
                               input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata,
                               input logic [DW-1:0] wmask);
    sb_entry_t e;
    @(negedge clk);
    checkOutput("req_rdy0", req_rdy[0], exp_run);
    checkOutput("req_rdy1", req_rdy[1], exp_run);
    req_vld   = vld;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    if (vld && exp_run) begin
      if (wr) begin
        model[addr] = (model[addr] & ~wmask) | (wdata & wmask);
      end else begin
        e.data = model[addr];
        e.due  = cyc + 1;
        sbq0.push_back(e);
        e.due  = cyc + 2;
        sbq1.push_back(e);
      end
    end
  endtask

  // Reset pulse followed by a bounded wait for the zero-fill sweep. With
  // poke set, requests are held valid during the sweep, alternating write
  // and read of address 0; none may be accepted.
  task automatic doReset(input bit poke);
    int n0;
    int n1;
    @(negedge clk);
    rst     = 1'b1;
    req_vld = 1'b0;
    exp_run = 1'b0;
    sbq0.delete();
    sbq1.delete();
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_rdy", {62'd0, req_rdy}, 64'd0);
      checkOutput("rst_init_done", {62'd0, init_done}, 64'd0);
    end
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    if (poke) begin
      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_addr  = '0;
      req_wdata = '1;
      req_wmask = '1;
    end
    n0 = 0;
    n1 = 0;
    for (int i = 1; i <= 40 && (n0 == 0 || n1 == 0); i++) begin
      @(posedge clk);
      #1;
      if (init_done[0] && n0 == 0) n0 = i;
      if (init_done[1] && n1 == 0) n1 = i;
      if (poke && init_done == 2'b00) begin
        checkOutput("init_rdy", {62'd0, req_rdy}, 64'd0);
        req_wr = ~req_wr;
      end
    end
    req_vld = 1'b0;
    checkOutput("init_cycles0", n0, 17);
    checkOutput("init_cycles1", n1, 17);
    exp_run = 1'b1;
  endtask

  // Response monitor, sampled 1 ns after each rising edge. During reset both
  // outputs must be zero; a response must match the queue head in data and
  // cycle; between responses the data output must hold the last value, and
  // a queued response whose cycle has passed is reported missing.
  always @(posedge clk) begin
    sb_entry_t head;
    int        pend;
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      pend = (d == 0) ? sbq0.size() : sbq1.size();
      if (pend > 0) head = (d == 0) ? sbq0[0] : sbq1[0];
      if (rst) begin
        checkOutput($sformatf("rst_rsp_vld%0d", d), {63'd0, rsp_vld[d]}, 64'd0);
        checkOutput($sformatf("rst_rsp_rdata%0d", d), {52'd0, rsp_rdata[d]}, 64'd0);
        last_data[d] = '0;
      end else if (rsp_vld[d]) begin
        if (pend == 0) begin
          checkOutput($sformatf("unexpected_rsp%0d", d), 64'd1, 64'd0);
        end else begin
          checkOutput($sformatf("rsp_data%0d", d), {52'd0, rsp_rdata[d]}, {52'd0, head.data});
          checkOutput($sformatf("rsp_cycle%0d", d), cyc, head.due);
          last_data[d] = head.data;
          if (d == 0) head = sbq0.pop_front();
          else        head = sbq1.pop_front();
        end
      end else begin
        checkOutput($sformatf("hold_rdata%0d", d), {52'd0, rsp_rdata[d]}, {52'd0, last_data[d]});
        if (pend > 0 && head.due <= cyc) begin
          checkOutput($sformatf("missing_rsp%0d", d), 64'd0, 64'd1);
          if (d == 0) head = sbq0.pop_front();
          else        head = sbq1.pop_front();
        end
      end
    end
  end

  // Main sequence: sweep and zero read-back, write-then-read, masked
  // writes, back-to-back reads, zero-mask write, random traffic, reset with
  // a read in flight, and requests presented during the sweep.
  initial begin
    last_data[0] = '0;
    last_data[1] = '0;
    doReset(1'b0);

    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, AW'(a), '0, '0);

    applyStimulus(1'b1, 1'b1, 4'd3, 12'h5A5, '1);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0);

    applyStimulus(1'b1, 1'b1, 4'd7, '1, '1);
    applyStimulus(1'b1, 1'b1, 4'd7, '0, 12'h00F);
    applyStimulus(1'b1, 1'b0, 4'd7, '0, '0);

    applyStimulus(1'b1, 1'b1, 4'd1, 12'h111, '1);
    applyStimulus(1'b1, 1'b1, 4'd2, 12'h222, '1);
    applyStimulus(1'b1, 1'b0, 4'd1, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'd2, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0);

    applyStimulus(1'b1, 1'b1, 4'd2, 12'hABC, 12'h000);
    applyStimulus(1'b1, 1'b0, 4'd2, '0, '0);

    repeat (80) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), DW'($urandom));
    end
    repeat (4) applyStimulus(1'b0, 1'b0, '0, '0, '0);

    applyStimulus(1'b1, 1'b1, 4'd5, 12'h0F0, '1);
    applyStimulus(1'b1, 1'b0, 4'd5, '0, '0);
    doReset(1'b1);

    applyStimulus(1'b1, 1'b0, 4'd0, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'd3, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'd5, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'd7, '0, '0);
    repeat (5) applyStimulus(1'b0, 1'b0, '0, '0, '0);

    checkOutput("sb_empty0", sbq0.size(), 0);
    checkOutput("sb_empty1", sbq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
